// File: rtl/core_pkg.sv
// core_pkg: shared fetch widths and the {pc, inst} entry carried from fetch to decode
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  typedef logic [XLEN-1:0] Addr;
  typedef logic [ILEN-1:0] Inst;
  typedef struct packed {
    Addr pc;
    Inst inst;
  } FetchEntry;
endpackage

// File: rtl/inst_fetcher_fifo.sv
// fifo: flushable circular buffer with one push and one pop per cycle
module fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wvalid,
  output logic                   wready,
  input  T                       wdata,
  output logic                   rvalid,
  input  logic                   rready,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  // A full buffer still takes a write when the head leaves in the same cycle; flush wins over both ports
  always_comb begin
    rvalid = count_q != '0;
    rdata = mem_q[rptr_q];
    count = count_q;
    wready = (count_q != CW'(DEPTH)) || rready;
    push = wvalid && wready && !flush;
    pop = rvalid && rready && !flush;
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // Storage is not reset; only occupied slots are ever presented on rdata
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: PC owner and fetch queue feeding decode; INST_FETCHER_BYPASS_EN forwards a response straight to decode when the queue is empty
module inst_fetcher
  import core_pkg::*;
#(
  parameter int  MEM_ADDR_WIDTH = 16,
  parameter int  FIFO_DEPTH     = 4,
  parameter Addr RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_ready,
  output logic                      mem_valid,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [ILEN-1:0]           mem_wdata,
  output logic [ILEN/8-1:0]         mem_wmask,
  input  logic                      mem_rvalid,
  input  logic [ILEN-1:0]           mem_rdata,
  output logic                      core_valid,
  input  logic                      core_ready,
  output logic [XLEN-1:0]           core_pc,
  output logic [ILEN-1:0]           core_inst,
  input  logic                      control_hazard,
  input  logic [XLEN-1:0]           control_hazard_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  Addr pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, discard_q, discard_d;
  logic fire, capture, push, pop, fifo_wready, fifo_rvalid;
  logic [CW-1:0] count;
  FetchEntry head, entry;
`ifdef INST_FETCHER_BYPASS_EN
  logic bypass;
`endif
  assign mem_wen = 1'b0;
  assign mem_wdata = '0;
  assign mem_wmask = '0;
  // Issue only while every in-flight word has a guaranteed slot; reset and redirect suppress issue and capture
  always_comb begin
    mem_valid = !rst && !control_hazard && ((count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    mem_addr = pc_q[MEM_ADDR_WIDTH+1:2];
    fire = mem_valid && mem_ready;
    capture = mem_rvalid && inflight_q && !discard_q && !control_hazard && !rst;
    entry = '{pc: inflight_pc_q, inst: mem_rdata};
    pc_d = control_hazard ? (control_hazard_pc & ~Addr'(3)) : fire ? pc_q + Addr'(4) : pc_q;
    inflight_d = fire;
    inflight_pc_d = fire ? pc_q : inflight_pc_q;
    discard_d = control_hazard && inflight_q;
  end
  // Decode-side view: queue head, or the live response when the queue is empty and bypass is built in
  always_comb begin
`ifdef INST_FETCHER_BYPASS_EN
    bypass = capture && !fifo_rvalid;
    core_valid = (fifo_rvalid && !rst) || bypass;
    core_pc = bypass ? inflight_pc_q : head.pc;
    core_inst = bypass ? mem_rdata : head.inst;
    push = capture && !(bypass && core_ready);
`else
    core_valid = fifo_rvalid && !rst;
    core_pc = head.pc;
    core_inst = head.inst;
    push = capture;
`endif
    pop = fifo_rvalid && core_ready && !rst && !control_hazard;
  end
  // PC, in-flight tracking and late-response discard
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      discard_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q <= discard_d;
    end
  end
  fifo #(.T(FetchEntry), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (control_hazard),
    .wvalid (push),
    .wready (fifo_wready),
    .wdata  (entry),
    .rvalid (fifo_rvalid),
    .rready (pop),
    .rdata  (head),
    .count  (count)
  );
  // The issue rule reserves a slot for every request in flight, so a rejected push means the fetcher is broken
  assert property (@(posedge clk) disable iff (rst) push |-> fifo_wready);
endmodule
